// File: rtl/handshake_fifo.sv
// Synchronous valid/ready FIFO with first-word fall-through, occupancy count,
// watermark flags and a synchronous flush. Outputs depend only on state and rst.
module handshake_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 4,
    parameter int ALMOST_FULL  = DEPTH - 1,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_BITS-1:0]       s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_BITS-1:0]       m_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       almost_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        used;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic                 push, pop;

    always_comb begin
        // The extra pointer MSB makes a full buffer read as DEPTH, not 0.
        used     = wr_ptr_q - rd_ptr_q;
        s_ready  = !rst && (used != PW'(DEPTH));
        m_valid  = !rst && (used != '0);
        push     = s_valid && s_ready;
        pop      = m_valid && m_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        count        = rst ? '0 : used;
        almost_full  = (count >= PW'(ALMOST_FULL));
        almost_empty = (count <= PW'(ALMOST_EMPTY));
        m_data       = m_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q[AW-1:0]] <= s_data;
    end
endmodule

// File: tb/tb_handshake_fifo.sv
// Scoreboard bench for handshake_fifo: drivers queue expected beats on accepted
// pushes, a negedge monitor pops and compares every delivered beat.
module tb_handshake_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TOTAL_BEATS = 1067;

    logic          clk = 1'b0;
    logic          rst, flush, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic [CW-1:0] count;
    logic          almost_full, almost_empty;

    int            n_checks = 0;
    int            n_pass = 0;
    int            n_pops = 0;
    logic [DW-1:0] exp_q[$];
    bit            rand_done;

    always #5 clk = ~clk;

    handshake_fifo #(.DATA_BITS(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: sampled on the falling edge, i.e. the handshake the next edge commits.
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge clk) begin
        chk("count_le_depth", 32'(count <= CW'(DEPTH)), 1);
        if (!m_valid) chk("m_data_zero_when_idle", 32'(m_data), 0);
        if (!rst && !flush) begin
            if (hold_prev) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                n_pops++;
                if (exp_q.size() == 0) chk("unexpected_pop", 32'(m_data), 32'hFFFF_FFFF);
                else chk("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
        hold_prev = m_valid && !m_ready && !rst && !flush;
        prev_data = m_data;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Presents one beat, waits for acceptance (bounded), records the expectation.
    task automatic push(input logic [DW-1:0] d);
        bit ok = 0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1; break; end
        end
        chk("push_accept", 32'(ok), 1);
        if (ok) exp_q.push_back(d);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) begin ok = 1; break; end
        end
        chk("drain", 32'(ok), 1);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        // Reset values
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_almost_empty", 32'(almost_empty), 1);
        chk("rst_almost_full", 32'(almost_full), 0);
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 1);
        step();

        // Fill / drain with an extra beat held off while full
        push(8'hA1);
        chk("fill1_almost_empty", 32'(almost_empty), 1);
        push(8'hB2);
        chk("fill2_almost_empty", 32'(almost_empty), 0);
        chk("fill2_almost_full", 32'(almost_full), 0);
        push(8'hC3);
        chk("fill3_almost_full", 32'(almost_full), 1);
        push(8'hD4);
        chk("full_count", 32'(count), 4);
        chk("full_s_ready", 32'(s_ready), 0);
        chk("full_almost_full", 32'(almost_full), 1);
        s_valid = 1'b1; s_data = 8'hE5;
        step();
        chk("full_holdoff_count", 32'(count), 4);
        m_ready = 1'b1;
        @(negedge clk);
        chk("full_no_bypass", 32'(s_ready), 0);
        @(negedge clk);
        chk("s_ready_after_pop", 32'(s_ready), 1);
        chk("count_after_pop", 32'(count), 3);
        exp_q.push_back(8'hE5);
        step();
        s_valid = 1'b0;
        wait_drain();

        // Streaming at one beat per cycle
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = 8'(i);
            @(negedge clk);
            chk("stream_count", 32'(count), (i == 0) ? 0 : 1);
            chk("stream_m_valid", 32'(m_valid), (i == 0) ? 0 : 1);
            chk("stream_s_ready", 32'(s_ready), 1);
            if (s_ready) exp_q.push_back(8'(i));
            step();
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("stream_tail_m_data", 32'(m_data), 32'h13);
        wait_drain();

        // Random backpressure
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    while ($urandom_range(0, 9) >= 7) step();
                    push(8'(i));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    step();
                    m_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        m_ready = 1'b1;
        wait_drain();

        // Wrap-around: repeated fill then drain
        for (int k = 0; k < 10; k++) begin
            m_ready = 1'b0;
            for (int j = 0; j < 4; j++) push(8'(k * 16 + j));
            chk("wrap_full", 32'(count), 4);
            m_ready = 1'b1;
            wait_drain();
            chk("wrap_empty", 32'(count), 0);
        end

        // Flush beats stored, discarding a simultaneous push and pop
        m_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
        chk("pre_flush_count", 32'(count), 3);
        flush = 1'b1; s_valid = 1'b1; s_data = 8'hAB; m_ready = 1'b1;
        @(negedge clk);
        chk("flush_s_ready", 32'(s_ready), 1);
        step();
        flush = 1'b0; s_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_count", 32'(count), 0);
        chk("flush_m_valid", 32'(m_valid), 0);
        step();
        push(8'hCD);
        wait_drain();

        // Reset mid-stream
        m_ready = 1'b0;
        push(8'h77); push(8'h88);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst_s_ready", 32'(s_ready), 0);
            chk("midrst_m_valid", 32'(m_valid), 0);
            step();
        end
        rst = 1'b0;
        exp_q.delete();
        m_ready = 1'b1;
        @(negedge clk);
        chk("after_rst_count", 32'(count), 0);
        chk("after_rst_m_data", 32'(m_data), 0);
        chk("after_rst_almost_empty", 32'(almost_empty), 1);
        chk("after_rst_m_valid", 32'(m_valid), 0);
        step(); step();
        push(8'h5A);
        wait_drain();

        chk("total_pops", 32'(n_pops), TOTAL_BEATS);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
